rename_dispatch: RTL and testbench

Rename-and-dispatch stage that produces the instruction stream consumed by the issue queue. It maps architectural source and destination registers onto the 64-entry physical register file and allocates a fresh physical register for every writing instruction. It drives `rename_enque`, `rename_issueinfo`, `rename_instr_num` and the per-physical-register ready vector `busy`. It tracks result broadcasts from execution and memory, and restores committed state on FLUSH.

---
 rtl/rename_dispatch.sv | 136 +++++++++++++
 tb/tb_rename_dispatch.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_dispatch.sv
// Rename/dispatch stage: maps architectural registers onto 64 physical registers,
// allocates destinations from a free vector and tracks operand readiness.
module rename_dispatch (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         STALL,
    input  logic         FLUSH,
    input  logic         dec_valid,
    input  logic [4:0]   dec_srcA,
    input  logic [4:0]   dec_srcB,
    input  logic [4:0]   dec_dst,
    input  logic         dec_regwr,
    input  logic [151:0] dec_payload,
    output logic         dec_ready,
    input  logic         issue_halt,
    input  logic         exe_broadcast,
    input  logic [5:0]   exe_broadcast_map,
    input  logic         mem_broadcast,
    input  logic [5:0]   mem_broadcast_map,
    input  logic         rob_commit,
    input  logic [4:0]   rob_commit_arch,
    input  logic [5:0]   rob_commit_phys,
    output logic         rename_enque,
    output logic [169:0] rename_issueinfo,
    output logic [31:0]  rename_instr_num,
    output logic [63:0]  busy
);

    localparam int NUM_PHYS = 64;
    localparam int NUM_ARCH = 32;

    logic [5:0]  spec_map      [NUM_ARCH];
    logic [5:0]  commit_map    [NUM_ARCH];
    logic [5:0]  commit_map_nx [NUM_ARCH];
    logic [63:0] free_vec;
    logic [63:0] ready_vec;
    logic [31:0] seq;

    logic        need_alloc;
    logic        do_alloc;
    logic [5:0]  alloc_idx;
    logic        alloc_found;
    logic [63:0] alloc_bit;
    logic        commit_en;
    logic [63:0] commit_free_bit;
    logic [63:0] bcast_vec;
    logic [63:0] ref_vec;
    logic [5:0]  map_a;
    logic [5:0]  map_b;
    logic [5:0]  map_wr;

    assign need_alloc = dec_regwr & (dec_dst != 5'd0);
    assign dec_ready  = dec_valid & ~STALL & ~FLUSH & ~issue_halt &
                        (~need_alloc | (free_vec != 64'd0));
    assign do_alloc   = dec_ready & need_alloc;
    assign commit_en  = rob_commit & (rob_commit_arch != 5'd0);

    // Lowest-index free register; scanning downward lets the lowest hit win.
    always_comb begin
        alloc_idx   = 6'd0;
        alloc_found = 1'b0;
        for (int i = NUM_PHYS - 1; i >= 0; i--) begin
            if (free_vec[i]) begin
                alloc_idx   = 6'(i);
                alloc_found = 1'b1;
            end
        end
    end

    always_comb begin
        alloc_bit = 64'd0;
        if (do_alloc && alloc_found)
            alloc_bit[alloc_idx] = 1'b1;
        commit_free_bit = 64'd0;
        if (commit_en)
            commit_free_bit[commit_map[rob_commit_arch]] = 1'b1;
        bcast_vec = 64'd0;
        if (exe_broadcast && exe_broadcast_map != 6'd0)
            bcast_vec[exe_broadcast_map] = 1'b1;
        if (mem_broadcast && mem_broadcast_map != 6'd0)
            bcast_vec[mem_broadcast_map] = 1'b1;
    end

    // Committed map after this cycle's retirement; a flush restores from this.
    always_comb begin
        commit_map_nx = commit_map;
        if (commit_en)
            commit_map_nx[rob_commit_arch] = rob_commit_phys;
        ref_vec = 64'd0;
        for (int i = 0; i < NUM_ARCH; i++)
            ref_vec[commit_map_nx[i]] = 1'b1;
    end

    assign map_a  = spec_map[dec_srcA];
    assign map_b  = spec_map[dec_srcB];
    assign map_wr = need_alloc ? alloc_idx : spec_map[dec_dst];
    assign busy   = ready_vec | bcast_vec;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < NUM_ARCH; i++) begin
                spec_map[i]   <= 6'(i);
                commit_map[i] <= 6'(i);
            end
            free_vec         <= {32'hFFFF_FFFF, 32'h0000_0000};
            ready_vec        <= '1;
            seq              <= 32'd1;
            rename_enque     <= 1'b0;
            rename_issueinfo <= '0;
            rename_instr_num <= '0;
        end else begin
            commit_map <= commit_map_nx;
            if (!STALL && FLUSH) begin
                spec_map     <= commit_map_nx;
                free_vec     <= ~ref_vec;
                ready_vec    <= '1;
                rename_enque <= 1'b0;
            end else begin
                // Freed register joins after the allocator has sampled free_vec.
                free_vec  <= (free_vec & ~alloc_bit) | commit_free_bit;
                ready_vec <= (ready_vec | bcast_vec) & ~alloc_bit;
                if (do_alloc)
                    spec_map[dec_dst] <= alloc_idx;
                if (!STALL) begin
                    rename_enque <= dec_ready;
                    if (dec_ready) begin
                        rename_issueinfo <= {dec_payload, map_wr, map_b, map_a};
                        rename_instr_num <= seq;
                        seq              <= seq + 32'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rename_dispatch.sv
// Directed self-checking bench for rename_dispatch.
module tb_rename_dispatch;

    logic         CLK;
    logic         RESET;
    logic         STALL;
    logic         FLUSH;
    logic         dec_valid;
    logic [4:0]   dec_srcA;
    logic [4:0]   dec_srcB;
    logic [4:0]   dec_dst;
    logic         dec_regwr;
    logic [151:0] dec_payload;
    logic         dec_ready;
    logic         issue_halt;
    logic         exe_broadcast;
    logic [5:0]   exe_broadcast_map;
    logic         mem_broadcast;
    logic [5:0]   mem_broadcast_map;
    logic         rob_commit;
    logic [4:0]   rob_commit_arch;
    logic [5:0]   rob_commit_phys;
    logic         rename_enque;
    logic [169:0] rename_issueinfo;
    logic [31:0]  rename_instr_num;
    logic [63:0]  busy;

    int n_cmp;
    int n_bad;

    rename_dispatch dut (
        .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH),
        .dec_valid(dec_valid), .dec_srcA(dec_srcA), .dec_srcB(dec_srcB),
        .dec_dst(dec_dst), .dec_regwr(dec_regwr), .dec_payload(dec_payload),
        .dec_ready(dec_ready), .issue_halt(issue_halt),
        .exe_broadcast(exe_broadcast), .exe_broadcast_map(exe_broadcast_map),
        .mem_broadcast(mem_broadcast), .mem_broadcast_map(mem_broadcast_map),
        .rob_commit(rob_commit), .rob_commit_arch(rob_commit_arch),
        .rob_commit_phys(rob_commit_phys), .rename_enque(rename_enque),
        .rename_issueinfo(rename_issueinfo), .rename_instr_num(rename_instr_num),
        .busy(busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic clear_inputs();
        STALL = 0; FLUSH = 0; dec_valid = 0; dec_srcA = 0; dec_srcB = 0;
        dec_dst = 0; dec_regwr = 0; dec_payload = '0; issue_halt = 0;
        exe_broadcast = 0; exe_broadcast_map = 0; mem_broadcast = 0;
        mem_broadcast_map = 0; rob_commit = 0; rob_commit_arch = 0; rob_commit_phys = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        @(negedge CLK);
        RESET = 1'b0;
        #2;
        RESET = 1'b1;
    endtask

    task automatic set_instr(input logic [4:0] a, input logic [4:0] b,
                             input logic [4:0] d, input logic wr);
        dec_valid = 1'b1; dec_srcA = a; dec_srcB = b; dec_dst = d; dec_regwr = wr;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++;
        if (rename_enque !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_enque: got %0b want 0", rename_enque); end
        n_cmp++;
        if (rename_issueinfo !== 170'd0) begin n_bad++; $display("[TB] FAIL reset_issueinfo: got %h want 0", rename_issueinfo); end
        n_cmp++;
        if (rename_instr_num !== 32'd0) begin n_bad++; $display("[TB] FAIL reset_instr_num: got %0d want 0", rename_instr_num); end
        n_cmp++;
        if (busy !== {64{1'b1}}) begin n_bad++; $display("[TB] FAIL reset_busy: got %h want all ones", busy); end
    endtask

    task automatic test_basic();
        logic [151:0] pay;
        do_reset();
        pay = 152'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978_8796_A5;
        set_instr(5'd1, 5'd2, 5'd3, 1'b1);
        dec_payload = pay;
        #1;
        n_cmp++;
        if (dec_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL basic_ready: got %0b want 1", dec_ready); end
        tick();
        n_cmp++;
        if (rename_enque !== 1'b1) begin n_bad++; $display("[TB] FAIL basic_enque: got %0b want 1", rename_enque); end
        n_cmp++;
        if (rename_issueinfo[17:0] !== {6'd32, 6'd2, 6'd1}) begin
            n_bad++; $display("[TB] FAIL basic_maps: got wr=%0d b=%0d a=%0d want wr=32 b=2 a=1",
                              rename_issueinfo[17:12], rename_issueinfo[11:6], rename_issueinfo[5:0]);
        end
        n_cmp++;
        if (rename_issueinfo[169:18] !== pay) begin n_bad++; $display("[TB] FAIL basic_payload: got %h want %h", rename_issueinfo[169:18], pay); end
        n_cmp++;
        if (rename_instr_num !== 32'd1) begin n_bad++; $display("[TB] FAIL basic_instr_num: got %0d want 1", rename_instr_num); end
        n_cmp++;
        if (busy[32] !== 1'b0) begin n_bad++; $display("[TB] FAIL basic_busy32: got %0b want 0", busy[32]); end
        // Source equal to destination reads the pre-update mapping
        set_instr(5'd3, 5'd2, 5'd3, 1'b1);
        tick();
        n_cmp++;
        if (rename_issueinfo[17:0] !== {6'd33, 6'd2, 6'd32}) begin
            n_bad++; $display("[TB] FAIL rerename_maps: got wr=%0d b=%0d a=%0d want wr=33 b=2 a=32",
                              rename_issueinfo[17:12], rename_issueinfo[11:6], rename_issueinfo[5:0]);
        end
        n_cmp++;
        if (rename_instr_num !== 32'd2) begin n_bad++; $display("[TB] FAIL rerename_instr_num: got %0d want 2", rename_instr_num); end
        dec_valid = 1'b0;
        #1;
        n_cmp++;
        if (busy[33] !== 1'b0) begin n_bad++; $display("[TB] FAIL bcast_before: got %0b want 0", busy[33]); end
        exe_broadcast = 1'b1; exe_broadcast_map = 6'd33;
        #1;
        n_cmp++;
        if (busy[33] !== 1'b1) begin n_bad++; $display("[TB] FAIL bcast_bypass: got %0b want 1", busy[33]); end
        tick();
        exe_broadcast = 1'b0;
        #1;
        n_cmp++;
        if (busy[33] !== 1'b1) begin n_bad++; $display("[TB] FAIL bcast_latched: got %0b want 1", busy[33]); end
        n_cmp++;
        if (rename_enque !== 1'b0) begin n_bad++; $display("[TB] FAIL bcast_enque: got %0b want 0", rename_enque); end
        n_cmp++;
        if (busy[32] !== 1'b0) begin n_bad++; $display("[TB] FAIL bcast_busy32: got %0b want 0", busy[32]); end
    endtask

    task automatic test_free_exhaust();
        do_reset();
        for (int k = 0; k < 32; k++) begin
            set_instr(5'd0, 5'd0, 5'(((k + 2) % 31) + 1), 1'b1);
            tick();
            n_cmp++;
            if (rename_enque !== 1'b1 || rename_issueinfo[17:12] !== 6'(32 + k) ||
                rename_instr_num !== 32'(k + 1)) begin
                n_bad++; $display("[TB] FAIL exhaust_alloc%0d: got enq=%0b wr=%0d num=%0d want enq=1 wr=%0d num=%0d",
                                  k, rename_enque, rename_issueinfo[17:12], rename_instr_num, 32 + k, k + 1);
            end
        end
        set_instr(5'd0, 5'd0, 5'd7, 1'b1);
        #1;
        n_cmp++;
        if (dec_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL exhaust_ready_empty: got %0b want 0", dec_ready); end
        tick();
        n_cmp++;
        if (rename_enque !== 1'b0) begin n_bad++; $display("[TB] FAIL exhaust_enque_empty: got %0b want 0", rename_enque); end
        rob_commit = 1'b1; rob_commit_arch = 5'd3; rob_commit_phys = 6'd32;
        #1;
        n_cmp++;
        if (dec_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL exhaust_ready_commit_cycle: got %0b want 0", dec_ready); end
        tick();
        rob_commit = 1'b0;
        #1;
        n_cmp++;
        if (dec_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL exhaust_ready_after_commit: got %0b want 1", dec_ready); end
        tick();
        dec_valid = 1'b0;
        n_cmp++;
        if (rename_enque !== 1'b1 || rename_issueinfo[17:12] !== 6'd3 || rename_instr_num !== 32'd33) begin
            n_bad++; $display("[TB] FAIL exhaust_reuse: got enq=%0b wr=%0d num=%0d want enq=1 wr=3 num=33",
                              rename_enque, rename_issueinfo[17:12], rename_instr_num);
        end
    endtask

    task automatic test_store();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            set_instr(5'd0, 5'd0, 5'd1, 1'b1);
            tick();
        end
        set_instr(5'd0, 5'd0, 5'd5, 1'b1);
        tick();
        n_cmp++;
        if (rename_issueinfo[17:12] !== 6'd40) begin n_bad++; $display("[TB] FAIL store_setup: got %0d want 40", rename_issueinfo[17:12]); end
        set_instr(5'd5, 5'd1, 5'd5, 1'b0);
        tick();
        n_cmp++;
        if (rename_issueinfo[17:0] !== {6'd40, 6'd39, 6'd40} || rename_instr_num !== 32'd10) begin
            n_bad++; $display("[TB] FAIL store_maps: got wr=%0d b=%0d a=%0d num=%0d want wr=40 b=39 a=40 num=10",
                              rename_issueinfo[17:12], rename_issueinfo[11:6], rename_issueinfo[5:0], rename_instr_num);
        end
        set_instr(5'd0, 5'd0, 5'd6, 1'b1);
        tick();
        dec_valid = 1'b0;
        n_cmp++;
        if (rename_issueinfo[17:12] !== 6'd41) begin n_bad++; $display("[TB] FAIL store_no_alloc: got %0d want 41", rename_issueinfo[17:12]); end
    endtask

    task automatic test_flush();
        do_reset();
        set_instr(5'd0, 5'd0, 5'd1, 1'b1);
        tick();
        set_instr(5'd0, 5'd0, 5'd2, 1'b1);
        rob_commit = 1'b1; rob_commit_arch = 5'd1; rob_commit_phys = 6'd32;
        tick();
        rob_commit = 1'b0;
        n_cmp++;
        if (rename_enque !== 1'b1 || rename_issueinfo[17:12] !== 6'd33) begin
            n_bad++; $display("[TB] FAIL flush_setup: got enq=%0b wr=%0d want enq=1 wr=33", rename_enque, rename_issueinfo[17:12]);
        end
        FLUSH = 1'b1;
        set_instr(5'd1, 5'd2, 5'd4, 1'b1);
        #1;
        n_cmp++;
        if (dec_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL flush_ready: got %0b want 0", dec_ready); end
        tick();
        FLUSH = 1'b0;
        #1;
        n_cmp++;
        if (rename_enque !== 1'b0) begin n_bad++; $display("[TB] FAIL flush_enque: got %0b want 0", rename_enque); end
        n_cmp++;
        if (busy !== {64{1'b1}}) begin n_bad++; $display("[TB] FAIL flush_busy: got %h want all ones", busy); end
        tick();
        n_cmp++;
        if (rename_issueinfo[17:0] !== {6'd1, 6'd2, 6'd32} || rename_instr_num !== 32'd3) begin
            n_bad++; $display("[TB] FAIL flush_maps: got wr=%0d b=%0d a=%0d num=%0d want wr=1 b=2 a=32 num=3",
                              rename_issueinfo[17:12], rename_issueinfo[11:6], rename_issueinfo[5:0], rename_instr_num);
        end
        set_instr(5'd0, 5'd0, 5'd5, 1'b1);
        tick();
        dec_valid = 1'b0;
        n_cmp++;
        if (rename_issueinfo[17:12] !== 6'd33) begin n_bad++; $display("[TB] FAIL flush_free33: got %0d want 33", rename_issueinfo[17:12]); end
    endtask

    task automatic test_halt();
        do_reset();
        issue_halt = 1'b1;
        set_instr(5'd4, 5'd0, 5'd8, 1'b1);
        #1;
        n_cmp++;
        if (dec_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL halt_ready: got %0b want 0", dec_ready); end
        tick();
        tick();
        n_cmp++;
        if (rename_enque !== 1'b0) begin n_bad++; $display("[TB] FAIL halt_enque: got %0b want 0", rename_enque); end
        issue_halt = 1'b0;
        tick();
        dec_valid = 1'b0;
        n_cmp++;
        if (rename_enque !== 1'b1 || rename_issueinfo[17:0] !== {6'd32, 6'd0, 6'd4} || rename_instr_num !== 32'd1) begin
            n_bad++; $display("[TB] FAIL halt_release: got enq=%0b wr=%0d a=%0d num=%0d want enq=1 wr=32 a=4 num=1",
                              rename_enque, rename_issueinfo[17:12], rename_issueinfo[5:0], rename_instr_num);
        end
        STALL = 1'b1;
        set_instr(5'd0, 5'd0, 5'd9, 1'b1);
        tick();
        n_cmp++;
        if (rename_enque !== 1'b1 || rename_instr_num !== 32'd1) begin
            n_bad++; $display("[TB] FAIL stall_hold: got enq=%0b num=%0d want enq=1 num=1", rename_enque, rename_instr_num);
        end
        STALL = 1'b0;
        dec_valid = 1'b0;
        tick();
        n_cmp++;
        if (rename_enque !== 1'b0) begin n_bad++; $display("[TB] FAIL halt_once: got %0b want 0", rename_enque); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        RESET = 1'b1;
        clear_inputs();
        test_reset();
        test_basic();
        test_free_exhaust();
        test_store();
        test_flush();
        test_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
